// File: rtl/eth_measurer_pkg.sv
// eth_measurer_pkg: shared state type, header layout offsets and constants for the latency measurer TX/RX paths
package eth_measurer_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_PAD} tx_state_t;
  localparam int HDR_BYTES = 26;
  localparam int HDR_BITS = HDR_BYTES * 8;
  localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
  localparam int DST_OFF = 0;
  localparam int SRC_OFF = 6;
  localparam int TYPE_OFF = 12;
  localparam int ID_OFF = 14;
  localparam int PING_OFF = 18;
endpackage

// File: rtl/eth_measurer_tx.sv
// eth_measurer_tx: streams one broadcast ping frame per trigger as 8-bit AXI-Stream toward the TEMAC.
// ETH_MEASURER_TX_TIMESTAMP_EN adds current_time/tx_time/tx_time_valid for byte-0 timestamping.
module eth_measurer_tx
  import eth_measurer_pkg::*;
#(
  parameter logic [47:0] src_mac = 48'h00_00_00_00_00_00,
  parameter logic [31:0] identifier = 32'h0000_0000,
  parameter logic [15:0] ethertype = 16'h0800,
  parameter logic [15:0] frame_size = 16'd60,
  parameter logic [63:0] ping_init = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        trigger,
  output logic        busy,
  output logic [63:0] ping_id,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready
`ifdef ETH_MEASURER_TX_TIMESTAMP_EN
  ,
  input  logic [63:0] current_time,
  output logic [63:0] tx_time,
  output logic        tx_time_valid
`endif
);
  localparam logic [15:0] LAST_IDX = frame_size - 16'd1;
  tx_state_t state, state_nx;
  logic [HDR_BITS-1:0] hdr;
  logic [15:0] cnt;
  logic [63:0] ping_cnt, tx_ping;
  logic pending, hs, start, finish;
  assign m_axis_tvalid = state != ST_IDLE;
  assign busy = m_axis_tvalid;
  assign m_axis_tkeep = m_axis_tvalid;
  // Header drains from the top byte; zeros shifted in behind it form the padding.
  assign m_axis_tdata = hdr[HDR_BITS-1 -: 8];
  assign m_axis_tlast = m_axis_tvalid && cnt == LAST_IDX;
  assign hs = m_axis_tvalid && m_axis_tready;
  assign start = state == ST_IDLE && (trigger || pending);
  assign finish = hs && m_axis_tlast;
  always_comb begin
    state_nx = state;
    if (start) state_nx = ST_HEADER;
    else if (finish) state_nx = ST_IDLE;
    else if (hs && state == ST_HEADER && cnt == 16'(HDR_BYTES - 1)) state_nx = ST_PAD;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      hdr <= '0;
      cnt <= '0;
      pending <= 1'b0;
      ping_cnt <= ping_init;
      tx_ping <= '0;
      ping_id <= '1;
    end else begin
      state <= state_nx;
      pending <= start ? 1'b0 : pending || (trigger && busy);
      if (start) begin
        hdr <= {BCAST_MAC, src_mac, ethertype, identifier, ping_cnt};
        tx_ping <= ping_cnt;
      end else if (hs) begin
        hdr <= {hdr[HDR_BITS-9:0], 8'h00};
      end
      if (hs) cnt <= finish ? '0 : cnt + 16'd1;
      if (finish) begin
        ping_id <= tx_ping;
        ping_cnt <= ping_cnt + 64'd1;
      end
    end
`ifdef ETH_MEASURER_TX_TIMESTAMP_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_time <= '0;
      tx_time_valid <= 1'b0;
    end else begin
      tx_time_valid <= finish;
      if (hs && cnt == '0) tx_time <= current_time;
    end
`endif
endmodule
